// File: rtl/mem_access_pkg.sv
// Shared encodings for the MEM-stage access unit: access sizes, FSM states
// and the alignment rule used to reject requests before memory is touched.
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam int NUM_LANES = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD     = 3'd1,
        ST_WR     = 3'd2,
        ST_RMW_RD = 3'd3,
        ST_RMW_WR = 3'd4,
        ST_RESP   = 3'd5
    } state_t;

    // Size 3 has no legal encoding, so it is folded into the misaligned case.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = addr_lo[0];
            SZ_WORD: misaligned = (addr_lo != 2'b00);
            default: misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_merge.sv
// Combinational lane logic: extracts and extends a load lane from a memory word,
// and builds the store word by replacing the addressed byte/half lanes.
module mem_lane_merge
    import mem_access_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        sign,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [NUM_LANES-1:0][7:0] word_b;
    logic [NUM_LANES-1:0][7:0] wdata_b;
    logic [NUM_LANES-1:0][7:0] store_b;

    assign word_b     = word;
    assign wdata_b    = wdata;
    assign store_word = store_b;

    genvar k;
    generate
        for (k = 0; k < NUM_LANES; k++) begin : g_lane
            localparam logic [1:0] K = 2'(k);
            logic       en;
            logic [7:0] src;

            // Store data is right-justified, so a half store feeds its lanes
            // from wdata bytes 0/1 regardless of which half is addressed.
            always_comb begin
                en  = 1'b0;
                src = wdata_b[k];
                case (size)
                    SZ_BYTE: begin
                        en  = (addr_lo == K);
                        src = wdata_b[0];
                    end
                    SZ_HALF: begin
                        en  = (addr_lo[1] == K[1]);
                        src = wdata_b[k % 2];
                    end
                    SZ_WORD: en = 1'b1;
                    default: en = 1'b0;
                endcase
            end

            assign store_b[k] = en ? src : word_b[k];
        end
    endgenerate

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel  = word_b[addr_lo];
        half_sel  = addr_lo[1] ? word[31:16] : word[15:0];
        load_data = word;
        case (size)
            SZ_BYTE: load_data = {{24{sign & byte_sel[7]}}, byte_sel};
            SZ_HALF: load_data = {{16{sign & half_sel[15]}}, half_sel};
            default: load_data = word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store controller: one request at a time, sub-word stores via
// read-modify-write, misaligned requests answered with an error and no memory traffic.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t            state, state_nxt;
    logic              accept;
    logic              req_bad;
    logic [1:0]        size_q;
    logic              sign_q;
    logic [1:0]        addr_lo_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] merge_buf;
    logic [DATA_W-1:0] lane_word;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] store_word;

    assign accept  = req_valid && (state == ST_IDLE);
    assign req_bad = misaligned(req_size, req_addr[1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Memory strobes come straight from the state register so an async reset
    // drops them at once and an uncommitted write never reaches memory.
    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        resp_valid = 1'b0;
        mem_wdata  = '0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_bad)                  state_nxt = ST_RESP;
                    else if (!req_we)             state_nxt = ST_RD;
                    else if (req_size == SZ_WORD) state_nxt = ST_WR;
                    else                          state_nxt = ST_RMW_RD;
                end
            end
            ST_RD: begin
                mem_read  = 1'b1;
                state_nxt = ST_RESP;
            end
            ST_WR: begin
                mem_write = 1'b1;
                mem_wdata = wdata_q;
                state_nxt = ST_RESP;
            end
            ST_RMW_RD: begin
                mem_read  = 1'b1;
                state_nxt = ST_RMW_WR;
            end
            ST_RMW_WR: begin
                mem_write = 1'b1;
                mem_wdata = store_word;
                state_nxt = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                state_nxt  = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Only RD and RMW_WR consume lane logic; mem_rdata is live in RD only.
    assign lane_word = (state == ST_RMW_WR) ? merge_buf : mem_rdata;

    mem_lane_merge u_lane_merge (
        .word       (lane_word),
        .addr_lo    (addr_lo_q),
        .size       (size_q),
        .sign       (sign_q),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            size_q     <= SZ_BYTE;
            sign_q     <= 1'b0;
            addr_lo_q  <= 2'b00;
            wdata_q    <= '0;
            merge_buf  <= '0;
            mem_addr   <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            if (accept) begin
                size_q    <= req_size;
                sign_q    <= req_signed;
                addr_lo_q <= req_addr[1:0];
                wdata_q   <= req_wdata;
                mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                if (req_bad) begin
                    resp_rdata <= '0;
                    resp_err   <= 1'b1;
                end
            end
            case (state)
                ST_RD: begin
                    resp_rdata <= load_data;
                    resp_err   <= 1'b0;
                end
                ST_RMW_RD: merge_buf <= mem_rdata;
                ST_WR, ST_RMW_WR: begin
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a 32-word data memory model.
module tb_mem_access_unit;
    import mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem [32];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    assign mem_rdata = mem_read ? mem[mem_addr[6:2]] : 32'hxxxxxxxx;

    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[6:2]] <= mem_wdata;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Presents a request while the unit is idle; returns 1ns after the accept edge.
    task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata);
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        req_valid  = 1'b1;
        cyc();
        req_valid  = 1'b0;
    endtask

    task automatic load_chk(input string tag, input logic [1:0] size, input logic sgn,
                            input logic [31:0] addr, input logic [31:0] exp);
        issue(1'b0, size, sgn, addr, 32'h0);
        chk({tag, ".rd"}, mem_read, 1);
        chk({tag, ".ready_lo"}, req_ready, 0);
        chk({tag, ".addr"}, mem_addr, addr & 32'hFFFF_FFFC);
        cyc();
        chk({tag, ".resp"}, resp_valid, 1);
        chk({tag, ".data"}, resp_rdata, exp);
        chk({tag, ".err"}, resp_err, 0);
        chk({tag, ".rd_off"}, mem_read, 0);
        cyc();
        chk({tag, ".resp_off"}, resp_valid, 0);
        chk({tag, ".hold"}, resp_rdata, exp);
    endtask

    task automatic store_word_chk(input string tag, input logic [31:0] addr, input logic [31:0] data);
        issue(1'b1, SZ_WORD, 1'b0, addr, data);
        chk({tag, ".wr"}, mem_write, 1);
        chk({tag, ".rd"}, mem_read, 0);
        chk({tag, ".addr"}, mem_addr, addr);
        chk({tag, ".wdata"}, mem_wdata, data);
        chk({tag, ".early_resp"}, resp_valid, 0);
        cyc();
        chk({tag, ".resp"}, resp_valid, 1);
        chk({tag, ".wr_off"}, mem_write, 0);
        chk({tag, ".mem"}, mem[addr[6:2]], data);
        chk({tag, ".rdata0"}, resp_rdata, 0);
        cyc();
        chk({tag, ".resp_off"}, resp_valid, 0);
    endtask

    task automatic store_sub_chk(input string tag, input logic [1:0] size, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] exp_word);
        issue(1'b1, size, 1'b0, addr, wdata);
        chk({tag, ".rd"}, mem_read, 1);
        chk({tag, ".wr0"}, mem_write, 0);
        chk({tag, ".addr"}, mem_addr, addr & 32'hFFFF_FFFC);
        cyc();
        chk({tag, ".rd_off"}, mem_read, 0);
        chk({tag, ".wr"}, mem_write, 1);
        chk({tag, ".merged"}, mem_wdata, exp_word);
        chk({tag, ".early_resp"}, resp_valid, 0);
        cyc();
        chk({tag, ".resp"}, resp_valid, 1);
        chk({tag, ".wr_off"}, mem_write, 0);
        chk({tag, ".mem"}, mem[addr[6:2]], exp_word);
        cyc();
        chk({tag, ".resp_off"}, resp_valid, 0);
    endtask

    task automatic mis_chk(input string tag, input logic we, input logic [1:0] size, input logic [31:0] addr);
        issue(we, size, 1'b0, addr, 32'hDEAD_BEEF);
        chk({tag, ".resp"}, resp_valid, 1);
        chk({tag, ".err"}, resp_err, 1);
        chk({tag, ".data0"}, resp_rdata, 0);
        chk({tag, ".no_rd"}, mem_read, 0);
        chk({tag, ".no_wr"}, mem_write, 0);
        cyc();
        chk({tag, ".resp_off"}, resp_valid, 0);
        chk({tag, ".err_hold"}, resp_err, 1);
        chk({tag, ".no_rd2"}, mem_read | mem_write, 0);
        chk({tag, ".ready"}, req_ready, 1);
    endtask

    initial begin
        int nresp;
        int busy;
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        mem[1] = 32'h80FF_7F01;
        mem[4] = 32'hAABB_CCDD;
        mem[5] = 32'hCAFE_BABE;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = SZ_BYTE;
        req_signed = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst.ready", req_ready, 1);
        chk("rst.resp_valid", resp_valid, 0);
        chk("rst.rdata", resp_rdata, 0);
        chk("rst.err", resp_err, 0);
        chk("rst.rd_wr", {mem_read, mem_write}, 0);
        chk("rst.addr", mem_addr, 0);
        chk("rst.wdata", mem_wdata, 0);
        rst_n = 1'b1;
        cyc();

        store_word_chk("sw08", 32'h08, 32'h1234_5678);
        load_chk("lw08", SZ_WORD, 1'b0, 32'h08, 32'h1234_5678);

        load_chk("lb06", SZ_BYTE, 1'b1, 32'h06, 32'hFFFF_FFFF);
        load_chk("lbu07", SZ_BYTE, 1'b0, 32'h07, 32'h0000_0080);
        load_chk("lb05", SZ_BYTE, 1'b1, 32'h05, 32'h0000_007F);
        load_chk("lhu06", SZ_HALF, 1'b0, 32'h06, 32'h0000_80FF);
        load_chk("lh06", SZ_HALF, 1'b1, 32'h06, 32'hFFFF_80FF);
        load_chk("lbu04", SZ_BYTE, 1'b0, 32'h04, 32'h0000_0001);

        store_sub_chk("sb12", SZ_BYTE, 32'h12, 32'hEEEE_EE11, 32'hAA11_CCDD);
        store_sub_chk("sh10", SZ_HALF, 32'h10, 32'hFFFF_2233, 32'hAA11_2233);

        mis_chk("mis_lw06", 1'b0, SZ_WORD, 32'h06);
        mis_chk("mis_sh03", 1'b1, SZ_HALF, 32'h03);
        mis_chk("mis_sz3", 1'b0, 2'd3, 32'h00);
        load_chk("lw_after_err", SZ_WORD, 1'b0, 32'h10, 32'hAA11_2233);

        // Valid held high, alternating sw/lw back to back.
        for (int t = 0; t < 4; t++) begin
            req_we     = (t % 2 == 0);
            req_size   = SZ_WORD;
            req_signed = 1'b0;
            req_addr   = 32'h20 + 32'(4 * (t / 2));
            req_wdata  = 32'h5A00_0000 + 32'(t);
            req_valid  = 1'b1;
            cyc();
            if (t == 3) req_valid = 1'b0;
            nresp = 0;
            busy  = 0;
            for (int c = 0; c < 6 && !req_ready; c++) begin
                busy++;
                if (resp_valid) begin
                    nresp++;
                    if (t % 2 == 1) chk("hs.ldata", resp_rdata, 32'h5A00_0000 + 32'(t - 1));
                end
                cyc();
            end
            chk("hs.nresp", nresp, 1);
            chk("hs.busy", busy, 2);
        end
        nresp = 0;
        for (int c = 0; c < 3; c++) begin
            if (resp_valid || mem_read || mem_write) nresp++;
            cyc();
        end
        chk("hs.quiet", nresp, 0);
        chk("hs.mem20", mem[8], 32'h5A00_0000);
        chk("hs.mem24", mem[9], 32'h5A00_0002);

        // Reset during the read half of a read-modify-write.
        issue(1'b1, SZ_BYTE, 1'b0, 32'h15, 32'h0000_0055);
        chk("rmw_rst.rd", mem_read, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rmw_rst.rd_wr", {mem_read, mem_write}, 0);
        chk("rmw_rst.ready", req_ready, 1);
        chk("rmw_rst.resp", resp_valid, 0);
        chk("rmw_rst.addr", mem_addr, 0);
        chk("rmw_rst.wdata", mem_wdata, 0);
        chk("rmw_rst.rdata", resp_rdata, 0);
        cyc();
        chk("rmw_rst.wr_held", mem_write, 0);
        rst_n = 1'b1;
        nresp = 0;
        for (int c = 0; c < 3; c++) begin
            if (resp_valid || mem_write) nresp++;
            cyc();
        end
        chk("rmw_rst.no_resp", nresp, 0);
        chk("rmw_rst.mem", mem[5], 32'hCAFE_BABE);
        load_chk("rmw_rst.lw", SZ_WORD, 1'b0, 32'h14, 32'hCAFE_BABE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
